// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL acquisition/tracking controller.
package adpll_pkg;
  localparam int CODE_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  function automatic int unsigned midscale(int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Clamp instead of wrapping so a runaway loop parks the DCO at a rail.
  function automatic logic [31:0] sat_step(logic [31:0] code, logic [31:0] step,
                                           logic up, logic [31:0] max_code);
    if (up) return ((max_code - code) < step) ? max_code : code + step;
    return (code < step) ? 32'd0 : code - step;
  endfunction
endpackage

// File: rtl/adpll_lock_detector.sv
// Tracks event direction history and decides when the loop gains or loses lock.
module adpll_lock_detector import adpll_pkg::*; #(
  parameter int LOCK_CNT   = 32,
  parameter int UNLOCK_RUN = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   ev,
  input  dir_t   ev_dir,
  input  state_t mode,
  input  logic   clear,
  output logic   reversal,
  output logic   lock_hit,
  output logic   unlock_hit
);
  localparam int ALT_W = $clog2(LOCK_CNT + 1);
  localparam int RUN_W = $clog2(UNLOCK_RUN + 1);

  logic [ALT_W-1:0] alt_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  dir_t             last_dir;

  assign reversal   = ev && (last_dir != DIR_NONE) && (ev_dir != last_dir);
  assign run_next   = reversal ? RUN_W'(1) : run_cnt + 1'b1;
  assign lock_hit   = ev && (mode == ST_FINE) && reversal &&
                      (alt_cnt == ALT_W'(LOCK_CNT - 1));
  assign unlock_hit = ev && (mode == ST_LOCKED) && (run_next == RUN_W'(UNLOCK_RUN));

  // Counters only move in their own mode, so each starts from zero on mode entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alt_cnt  <= '0;
      run_cnt  <= '0;
      last_dir <= DIR_NONE;
    end else if (clear) begin
      alt_cnt  <= '0;
      run_cnt  <= '0;
      last_dir <= DIR_NONE;
    end else if (ev) begin
      last_dir <= ev_dir;
      if (mode == ST_FINE)   alt_cnt <= reversal ? alt_cnt + 1'b1 : '0;
      if (mode == ST_LOCKED) run_cnt <= run_next;
    end
  end
endmodule

// File: rtl/adpll_loop_ctrl.sv
// ADPLL acquisition/tracking FSM and DCO code register.
// Define ADPLL_LOCK_STATS_EN to add the lock_loss_cnt statistics output.
module adpll_loop_ctrl import adpll_pkg::*; #(
  parameter int CODE_W      = CODE_W_DEF,
  parameter int COARSE_STEP = 16,
  parameter int LOCK_CNT    = 32,
  parameter int UNLOCK_RUN  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              up_in,
  input  logic              dn_in,
  output logic [CODE_W-1:0] dco_code,
  output logic [1:0]        state_o,
  output logic              locked
`ifdef ADPLL_LOCK_STATS_EN
  ,
  output logic [7:0]        lock_loss_cnt
`endif
);
  localparam logic [CODE_W-1:0] MID_CODE = CODE_W'(midscale(CODE_W));
  localparam logic [31:0]       MAX_CODE = 32'((64'd1 << CODE_W) - 64'd1);

  state_t            state, state_next;
  logic [CODE_W-1:0] code_next;
  logic [31:0]       step;
  logic              ev, clear, reversal, lock_hit, unlock_hit;
  dir_t              ev_dir;

  // Events are ignored in IDLE and whenever the loop is being disabled.
  assign ev       = enable && (up_in ^ dn_in) && (state != ST_IDLE);
  assign ev_dir   = up_in ? DIR_UP : DIR_DN;
  assign step     = (state == ST_COARSE) ? 32'(COARSE_STEP) : 32'd1;
  assign clear    = (state_next == ST_IDLE) ||
                    ((state_next == ST_COARSE) && (state != ST_COARSE));
  assign state_o  = state;
  assign locked   = (state == ST_LOCKED);

  adpll_lock_detector #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_RUN (UNLOCK_RUN)
  ) u_lock_det (
    .clk        (clk),
    .reset_n    (reset_n),
    .ev         (ev),
    .ev_dir     (ev_dir),
    .mode       (state),
    .clear      (clear),
    .reversal   (reversal),
    .lock_hit   (lock_hit),
    .unlock_hit (unlock_hit)
  );

  always_comb begin
    state_next = state;
    code_next  = dco_code;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      if (ev) code_next = CODE_W'(sat_step(32'(dco_code), step, up_in, MAX_CODE));
      case (state)
        ST_IDLE:   state_next = ST_COARSE;
        ST_COARSE: if (reversal) state_next = ST_FINE;
        ST_FINE:   if (lock_hit) state_next = ST_LOCKED;
        ST_LOCKED: if (unlock_hit) state_next = ST_COARSE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      dco_code <= MID_CODE;
    end else begin
      state    <= state_next;
      dco_code <= code_next;
    end
  end

`ifdef ADPLL_LOCK_STATS_EN
  // Survives enable toggling so firmware can read how often tracking dropped out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_cnt <= '0;
    end else if ((state == ST_LOCKED) && (state_next == ST_COARSE) &&
                 (lock_loss_cnt != 8'hFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Scoreboard bench for adpll_loop_ctrl: directed events with hand-computed codes.
module tb_adpll_loop_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       up_in;
  logic       dn_in;
  logic [9:0] dco_code;
  logic [1:0] state_o;
  logic       locked;
`ifdef ADPLL_LOCK_STATS_EN
  logic [7:0] lock_loss_cnt;
`endif

  typedef struct packed {
    logic [31:0] step;
    logic [9:0]  code;
    logic [1:0]  st;
    logic        lk;
    logic [7:0]  loss;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         step_no = 0;
  logic [7:0] exp_loss = 8'd0;

  adpll_loop_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .up_in         (up_in),
    .dn_in         (dn_in),
    .dco_code      (dco_code),
    .state_o       (state_o),
    .locked        (locked)
`ifdef ADPLL_LOCK_STATS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int step_id,
                             input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s at step %0d: got %0d, expected %0d", name, step_id, act, req);
    end
  endtask

  // Drive one cycle of inputs mid-period and queue what the following edge must produce.
  task automatic applyStimulus(input logic en, input logic up, input logic dn,
                               input logic [9:0] code, input logic [1:0] st, input logic lk);
    exp_t e;
    @(negedge clk);
    enable = en;
    up_in  = up;
    dn_in  = dn;
    @(posedge clk);
    step_no++;
    e.step = 32'(step_no);
    e.code = code;
    e.st   = st;
    e.lk   = lk;
    e.loss = exp_loss;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("dco_code", int'(e.step), 32'(dco_code), 32'(e.code));
        checkOutput("state_o", int'(e.step), 32'(state_o), 32'(e.st));
        checkOutput("locked", int'(e.step), 32'(locked), 32'(e.lk));
`ifdef ADPLL_LOCK_STATS_EN
        checkOutput("lock_loss_cnt", int'(e.step), 32'(lock_loss_cnt), 32'(e.loss));
`endif
      end
    end
  end

  initial begin : stimulus
    reset_n = 1'b0;
    enable  = 1'b0;
    up_in   = 1'b0;
    dn_in   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_code", 0, 32'(dco_code), 32'd512);
    checkOutput("reset_state", 0, 32'(state_o), 32'd0);
    checkOutput("reset_locked", 0, 32'(locked), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(1'b0, (i % 2) == 1, 1'b0, 10'd512, 2'd0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 10'd512, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd528, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd544, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd560, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd544, 2'd2, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 10'd545, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd546, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd545, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd544, 2'd2, 1'b0);
    for (int i = 1; i <= 32; i++)
      applyStimulus(1'b1, (i % 2) == 1, (i % 2) == 0,
                    ((i % 2) == 1) ? 10'd545 : 10'd544,
                    (i == 32) ? 2'd3 : 2'd2, i == 32);

    applyStimulus(1'b1, 1'b1, 1'b0, 10'd545, 2'd3, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd546, 2'd3, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd547, 2'd3, 1'b1);
    exp_loss = 8'd1;
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd548, 2'd1, 1'b0);

    for (int i = 1; i <= 29; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 10'(548 + 16 * i), 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd1023, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd1023, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 10'd1023, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd1007, 2'd2, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 10'd1007, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'd1007, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd1007, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd991, 2'd1, 1'b0);

    #3;
    reset_n = 1'b0;
    exp_loss = 8'd0;
    #1;
    checkOutput("async_reset_code", step_no, 32'(dco_code), 32'd512);
    checkOutput("async_reset_state", step_no, 32'(state_o), 32'd0);
    checkOutput("async_reset_locked", step_no, 32'(locked), 32'd0);
`ifdef ADPLL_LOCK_STATS_EN
    checkOutput("async_reset_loss", step_no, 32'(lock_loss_cnt), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 10'd512, 2'd1, 1'b0);
    for (int i = 1; i <= 33; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, (i >= 32) ? 10'd0 : 10'(512 - 16 * i), 2'd1, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drain", step_no, 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adpll_loop_ctrl.md
Name: adpll_loop_ctrl

Overview:
- Acquisition/tracking controller for the ADPLL loop.
- Consumes the glitch-filtered UP/DN pulses from digital_filter and sequences the DCO tuning word through coarse acquisition, fine tracking and lock.
- Sits between digital_filter and the DCO control input.
- Flags lock and re-enters acquisition on loss of lock.

Parameters:
- CODE_W, 10, DCO tuning word width (bits).
- COARSE_STEP, 16, DCO code step applied per event in COARSE.
- LOCK_CNT, 32, consecutive alternating-direction events needed in FINE to declare lock.
- UNLOCK_RUN, 4, consecutive same-direction events in LOCKED that declare loss of lock.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = loop running; 0 = hold code and return to IDLE.
- up_in  in  1  filtered UP pulse (DCO too slow; increase code).
- dn_in  in  1  filtered DN pulse (DCO too fast; decrease code).
- dco_code  out  CODE_W  DCO tuning word.
- state_o  out  2  FSM state: 0 IDLE, 1 COARSE, 2 FINE, 3 LOCKED.
- locked  out  1  high only in LOCKED.

Behaviour:
- Reset (async assert, sync release): dco_code = 2^(CODE_W-1) (midscale, 512 at default), state IDLE, locked 0, all counters 0, last_dir = none.
- Event definition: up_in XOR dn_in, sampled on rising clk. up_in = dn_in (both 0 or both 1) is no event; nothing changes.
- Direction: +1 for UP, -1 for DN. At most one event per cycle.
- Latency: dco_code, state_o and locked update on the same edge that samples the event; visible one cycle after the input is presented.
- Step size: COARSE_STEP in COARSE, 1 in FINE and LOCKED, 0 in IDLE.
- Arithmetic: unsigned with saturation. Up-step clamps at 2^CODE_W-1; down-step clamps at 0. Never wraps.
- IDLE:
  - Code frozen.
  - enable=1 moves to COARSE on the next edge. An event in that same cycle is ignored.
- COARSE:
  - Each event steps the code by COARSE_STEP.
  - First event whose direction is opposite last_dir: apply that step, then go to FINE. The alternation counter starts at 0.
- FINE:
  - Each event steps the code by 1.
  - Event direction opposite last_dir: alt_cnt++.
  - Same direction: alt_cnt clears to 0.
  - Event that brings alt_cnt to LOCK_CNT: go to LOCKED, locked = 1 on that same edge.
- LOCKED:
  - Each event steps the code by 1.
  - Same-direction run counter run_cnt: increments on repeat direction, resets to 1 on reversal.
  - run_cnt reaching UNLOCK_RUN: go to COARSE, locked = 0, counters clear. The code is kept, not reset to midscale.
- last_dir updates on every event in COARSE, FINE and LOCKED. It clears to none on entry to IDLE or COARSE.
- enable=0 in any state: next edge goes to IDLE, locked = 0, counters clear, dco_code holds. A concurrent event is ignored.
- Saturated step: still counts as an event for direction and counters.
- Reset mid-operation: immediate return to reset values, including dco_code midscale.

Optional Feature:
- Macro: ADPLL_LOCK_STATS_EN.
- Defined:
  - Adds output lock_loss_cnt (8 bits, reset 0).
  - Increments on every LOCKED→COARSE transition; saturates at 255.
  - Not cleared by enable=0, only by reset_n.
- Undefined: port and counter absent. All other behaviour identical.

Decomposition:
- Package adpll_pkg holds:
  - State enum (IDLE, COARSE, FINE, LOCKED; 2-bit encoding as listed under state_o).
  - Direction encoding (none/up/down).
  - Function for saturating add/sub of a step on a CODE_W word.
  - Midscale constant.
- Sub-module adpll_lock_detector:
  - Owns alt_cnt, run_cnt and last_dir.
  - Inputs: event and direction, mode (FINE/LOCKED), clear.
  - Outputs: lock_hit, unlock_hit.
- The top-level FSM and code register stay in adpll_loop_ctrl.

Test Plan:
- Reset: reset_n=0, then release, enable=0 -> dco_code=512, state_o=0, locked=0 for 10 cycles; up_in pulses have no effect.
- Coarse acquisition: enable=1, then 3 UP events, then 1 DN -> code 512→528→544→560→544; state_o=2 after the DN.
- Lock: from FINE at 544, 32 alternating events UP,DN,… -> code toggles 545/544; locked=1 and state_o=3 on the 32nd event; an intermediate repeated direction restarts the count.
- Loss of lock: in LOCKED at code 544, 4 consecutive UP -> code 548, state_o=1, locked=0; with ADPLL_LOCK_STATS_EN, lock_loss_cnt=1.
- Saturation/illegal input: code near max in COARSE (1020), UP event -> code 1023 (no wrap); up_in=dn_in=1 for 5 cycles -> no code or state change.
- Mid-operation abort: enable=0 during FINE -> state_o=0 next cycle, code held; reset_n=0 asserted asynchronously between edges -> code 512 immediately.
